// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcode constants, fetch FSM states and instruction-length helper shared by front-end and decoder
package cpu_isa_pkg;
  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_MI  = 4'b0010;
  localparam logic [3:0] OP_ORI = 4'b1001;
  localparam logic [3:0] OP_XRI = 4'b1011;
  localparam logic [3:0] OP_SMI = 4'b1100;
  localparam logic [3:0] OP_SBI = 4'b1101;
  localparam logic [3:0] OP_ANI = 4'b1110;
  localparam logic [3:0] OP_CMI = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_OP,
    S_WAIT_OP,
    S_REQ_IMM,
    S_WAIT_IMM,
    S_ISSUE
  } fetch_state_e;

  // Opcodes that are followed by an immediate/address byte in program memory
  function automatic logic is_two_byte(input logic [3:0] op);
    return op inside {OP_LD, OP_ST, OP_MI, OP_ORI, OP_XRI, OP_SMI, OP_SBI, OP_ANI, OP_CMI};
  endfunction
endpackage

// File: rtl/instr_len_lut.sv
// instr_len_lut: combinational opcode -> "carries an operand byte" lookup
module instr_len_lut
  import cpu_isa_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_two_byte
);
  assign o_two_byte = is_two_byte(i_opcode);
endmodule

// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: fetches opcode/operand bytes from program memory and issues them to the decoder
module instr_fetch_issue
  import cpu_isa_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instruction,
  output logic [7:0]        operand,
  output logic              two_byte,
  output logic [ADDR_W-1:0] pc
);
  fetch_state_e      r_state, w_next, w_restart;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_instr, r_operand;
  logic              r_two, r_flush;
  logic              w_two, w_req, w_wait, w_take;

  instr_len_lut u_len (
    .i_opcode   (mem_rdata[7:4]),
    .o_two_byte (w_two)
  );

  assign w_req     = r_state == S_REQ_OP || r_state == S_REQ_IMM;
  assign w_wait    = r_state == S_WAIT_OP || r_state == S_WAIT_IMM;
  // A response is kept only if no redirect happened since (or during) its request
  assign w_take    = w_wait && mem_rvalid && !r_flush && !pc_load;
  assign w_restart = enable ? S_REQ_OP : S_IDLE;

  assign mem_req     = w_req;
  assign mem_addr    = w_req ? r_pc : '0;
  assign instr_valid = r_state == S_ISSUE;
  assign instruction = r_instr;
  assign operand     = r_operand;
  assign two_byte    = r_two;
  assign pc          = r_pc;

  // Next-state: a discarded response or a dropped/accepted issue slot restarts the fetch
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = enable ? S_REQ_OP : S_IDLE;
      S_REQ_OP:   w_next = S_WAIT_OP;
      S_REQ_IMM:  w_next = S_WAIT_IMM;
      S_WAIT_OP:  w_next = !mem_rvalid ? S_WAIT_OP : !w_take ? w_restart : w_two ? S_REQ_IMM : S_ISSUE;
      S_WAIT_IMM: w_next = !mem_rvalid ? S_WAIT_IMM : w_take ? S_ISSUE : w_restart;
      S_ISSUE:    w_next = (instr_ready || pc_load) ? w_restart : S_ISSUE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State, PC and issue-slot registers; a redirect while a read is in flight (REQ or WAIT) marks it stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_operand <= '0;
      r_two     <= 1'b0;
      r_flush   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (pc_load) r_pc <= pc_load_val;
      else if (w_take) r_pc <= r_pc + 1'b1;
      if (w_wait && mem_rvalid) r_flush <= 1'b0;
      else if (pc_load && (w_req || w_wait)) r_flush <= 1'b1;
      if (w_take && r_state == S_WAIT_OP) begin
        r_instr   <= mem_rdata;
        r_two     <= w_two;
        r_operand <= '0;
      end
      if (w_take && r_state == S_WAIT_IMM) r_operand <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_instr_fetch_issue.sv
// tb_instr_fetch_issue: directed vectors and corner sequences for the instruction fetch/issue front-end
module tb_instr_fetch_issue;
  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       exp_two;
    logic [7:0] exp_opnd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, en0, en1, ld, rdy0, rdy1, inj;
  logic [7:0] ld_val;
  logic       req [2];
  logic [7:0] addr [2];
  logic       vld [2];
  logic [7:0] ins [2];
  logic [7:0] opd [2];
  logic       two [2];
  logic [7:0] pcv [2];
  logic       rv [2]   = '{1'b0, 1'b0};
  logic [7:0] rd [2]   = '{8'h00, 8'h00};
  logic       busy [2] = '{1'b0, 1'b0};
  int         cnt [2];
  logic [7:0] ad [2];
  logic       rv0;
  logic [7:0] mem [256];
  int         lat = 1;
  int         nreq0 = 0;
  int         nreq1 = 0;
  int         total = 0;
  int         bad = 0;
  vec_t       tbl [14];

  always #5 clk = ~clk;
  assign rv0 = rv[0] | inj;

  instr_fetch_issue #(.ADDR_W(8), .RESET_PC(8'h00)) d0 (
    .clk(clk), .rst(rst), .enable(en0), .pc_load(ld), .pc_load_val(ld_val),
    .mem_req(req[0]), .mem_addr(addr[0]), .mem_rdata(rd[0]), .mem_rvalid(rv0),
    .instr_valid(vld[0]), .instr_ready(rdy0), .instruction(ins[0]), .operand(opd[0]),
    .two_byte(two[0]), .pc(pcv[0])
  );

  instr_fetch_issue #(.ADDR_W(8), .RESET_PC(8'hFF)) d1 (
    .clk(clk), .rst(rst), .enable(en1), .pc_load(1'b0), .pc_load_val(8'h00),
    .mem_req(req[1]), .mem_addr(addr[1]), .mem_rdata(rd[1]), .mem_rvalid(rv[1]),
    .instr_valid(vld[1]), .instr_ready(rdy1), .instruction(ins[1]), .operand(opd[1]),
    .two_byte(two[1]), .pc(pcv[1])
  );

  // Program memory with programmable latency, one outstanding read per port
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rv[i] <= 1'b0;
      if (req[i]) begin
        if (lat <= 1) begin
          rv[i] <= 1'b1;
          rd[i] <= mem[addr[i]];
        end else begin
          busy[i] <= 1'b1;
          cnt[i]  <= lat - 1;
          ad[i]   <= addr[i];
        end
      end else if (busy[i]) begin
        if (cnt[i] <= 1) begin
          rv[i]   <= 1'b1;
          rd[i]   <= mem[ad[i]];
          busy[i] <= 1'b0;
        end else cnt[i] <= cnt[i] - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (req[0] === 1'b1) nreq0++;
    if (req[1] === 1'b1) nreq1++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int k, output int cyc);
    bit seen = 0;
    cyc = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      seen = vld[k] === 1'b1;
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_req(input int k, output logic [7:0] a, output bit saw_valid);
    bit seen = 0;
    int n = 0;
    saw_valid = 0;
    a = 8'hxx;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (vld[k] === 1'b1) saw_valid = 1;
      seen = req[k] === 1'b1;
    end
    if (!seen) chk("req_timeout", 0, 1);
    else a = addr[k];
  endtask

  task automatic accept0(input logic keep_enable);
    rdy0 = 1'b1;
    en0  = keep_enable;
    @(negedge clk);
    rdy0 = 1'b0;
  endtask

  initial begin
    int         cyc, n, a;
    logic [7:0] ra;
    bit         sv;
    logic [7:0] exp_pc;
    tbl[0]  = '{8'h46, 8'hEE, 1'b0, 8'h00};
    tbl[1]  = '{8'hC4, 8'h5A, 1'b1, 8'h5A};
    tbl[2]  = '{8'h00, 8'h12, 1'b1, 8'h12};
    tbl[3]  = '{8'h1F, 8'h34, 1'b1, 8'h34};
    tbl[4]  = '{8'h2A, 8'h77, 1'b1, 8'h77};
    tbl[5]  = '{8'h3B, 8'hEE, 1'b0, 8'h00};
    tbl[6]  = '{8'h9C, 8'h01, 1'b1, 8'h01};
    tbl[7]  = '{8'hA5, 8'hEE, 1'b0, 8'h00};
    tbl[8]  = '{8'hBF, 8'hFE, 1'b1, 8'hFE};
    tbl[9]  = '{8'hD0, 8'h80, 1'b1, 8'h80};
    tbl[10] = '{8'hE3, 8'h0F, 1'b1, 8'h0F};
    tbl[11] = '{8'hF1, 8'hAA, 1'b1, 8'hAA};
    tbl[12] = '{8'h8E, 8'hEE, 1'b0, 8'h00};
    tbl[13] = '{8'h7F, 8'hEE, 1'b0, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h46;
    mem[8'hFF] = 8'h46;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; ld = 1'b0; ld_val = 8'h00;
    rdy0 = 1'b0; rdy1 = 1'b0; inj = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {vld[0], req[0], addr[0], ins[0], opd[0], two[0]}, 32'h0);
    chk("reset_pc", pcv[0], 8'h00);
    chk("reset_pc_ff", pcv[1], 8'hFF);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    @(negedge clk);
    chk("stray_rvalid", {vld[0], pcv[0]}, {1'b0, 8'h00});

    n = nreq0;
    en0 = 1'b1;
    wait_valid(0, cyc);
    chk("onebyte_latency", cyc, 3);
    chk("onebyte_instr", {ins[0], opd[0], two[0]}, {8'h46, 8'h00, 1'b0});
    chk("onebyte_pc", pcv[0], 8'h01);
    chk("onebyte_reqs", nreq0 - n, 1);
    mem[8'h01] = 8'hC4;
    mem[8'h02] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_stable", {vld[0], req[0], ins[0], opd[0], pcv[0]}, {1'b1, 1'b0, 8'h46, 8'h00, 8'h01});
    end
    rdy0 = 1'b1;
    n = nreq0;
    @(negedge clk);
    chk("after_accept_req", {req[0], addr[0]}, {1'b1, 8'h01});
    rdy0 = 1'b0;
    en0 = 1'b0;
    wait_valid(0, cyc);
    chk("disable_midfetch", {ins[0], opd[0], two[0], pcv[0]}, {8'hC4, 8'h5A, 1'b1, 8'h03});
    chk("disable_reqs", nreq0 - n, 2);
    accept0(1'b0);
    n = nreq0;
    repeat (5) @(negedge clk);
    chk("idle_no_req", {nreq0 - n, 31'(vld[0])}, 0);

    mem[8'h00] = 8'hC4;
    mem[8'h01] = 8'h5A;
    ld = 1'b1; ld_val = 8'h00;
    @(negedge clk);
    ld = 1'b0;
    chk("load_in_idle", pcv[0], 8'h00);
    n = nreq0;
    en0 = 1'b1;
    wait_valid(0, cyc);
    chk("smi_instr", {ins[0], opd[0], two[0], pcv[0]}, {8'hC4, 8'h5A, 1'b1, 8'h02});
    chk("smi_reqs", nreq0 - n, 2);

    a = 8'h20;
    for (int i = 0; i < 14; i++) begin
      mem[a[7:0]] = tbl[i].b0;
      a++;
      if (tbl[i].exp_two) begin
        mem[a[7:0]] = tbl[i].b1;
        a++;
      end
    end
    ld = 1'b1; ld_val = 8'h20;
    n = nreq0;
    @(negedge clk);
    ld = 1'b0;
    chk("drop_slot", {vld[0], pcv[0], req[0], addr[0]}, {1'b0, 8'h20, 1'b1, 8'h20});
    exp_pc = 8'h20;
    for (int i = 0; i < 14; i++) begin
      exp_pc = exp_pc + (tbl[i].exp_two ? 8'd2 : 8'd1);
      wait_valid(0, cyc);
      chk($sformatf("vec%0d_instr", i), ins[0], tbl[i].b0);
      chk($sformatf("vec%0d_opnd", i), opd[0], tbl[i].exp_opnd);
      chk($sformatf("vec%0d_two", i), two[0], tbl[i].exp_two);
      chk($sformatf("vec%0d_pc", i), pcv[0], exp_pc);
      chk($sformatf("vec%0d_reqs", i), nreq0 - n, tbl[i].exp_two ? 2 : 1);
      n = nreq0;
      accept0(i != 13);
    end

    lat = 4;
    mem[8'h40] = 8'h46;
    mem[8'h10] = 8'h7F;
    ld = 1'b1; ld_val = 8'h40;
    @(negedge clk);
    ld = 1'b0;
    en0 = 1'b1;
    wait_req(0, ra, sv);
    chk("flush_first_addr", ra, 8'h40);
    @(negedge clk);
    ld = 1'b1; ld_val = 8'h30;
    @(negedge clk);
    ld_val = 8'h10;
    @(negedge clk);
    ld = 1'b0;
    chk("flush_pc_overwrite", pcv[0], 8'h10);
    wait_req(0, ra, sv);
    chk("flush_no_stale_issue", sv, 1'b0);
    chk("flush_next_addr", ra, 8'h10);
    wait_valid(0, cyc);
    chk("flush_instr", {ins[0], opd[0], two[0], pcv[0]}, {8'h7F, 8'h00, 1'b0, 8'h11});
    accept0(1'b0);

    mem[8'h50] = 8'hC4;
    mem[8'h51] = 8'h5A;
    ld = 1'b1; ld_val = 8'h50;
    @(negedge clk);
    ld = 1'b0;
    en0 = 1'b1;
    wait_req(0, ra, sv);
    chk("rst_op_addr", ra, 8'h50);
    wait_req(0, ra, sv);
    chk("rst_imm_addr", ra, 8'h51);
    @(negedge clk);
    rst = 1'b1;
    en0 = 1'b0;
    #1;
    chk("async_rst_now", {vld[0], pcv[0], ins[0]}, {1'b0, 8'h00, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    n = nreq0;
    sv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vld[0] === 1'b1) sv = 1;
    end
    chk("late_rvalid_ignored", {sv, pcv[0], ins[0], opd[0]}, {1'b0, 8'h00, 8'h00, 8'h00});
    chk("late_rvalid_no_req", nreq0 - n, 0);

    en1 = 1'b1;
    wait_req(1, ra, sv);
    chk("wrap_first_addr", ra, 8'hFF);
    wait_valid(1, cyc);
    chk("wrap_instr", {ins[1], opd[1], two[1]}, {8'h46, 8'h00, 1'b0});
    chk("wrap_pc", pcv[1], 8'h00);
    rdy1 = 1'b1;
    wait_req(1, ra, sv);
    chk("wrap_next_addr", ra, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
